// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: jump unit, program memory and decoder signals.
// The master modport is the fetch unit; the slave modport is its environment.
interface pc_fetch_if;
    // jump unit
    logic       pcoe;
    logic [7:0] pcin;
    logic [7:0] pcout;
    // issue control
    logic       halt;
    // program memory
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    // decoder
    logic [7:0] ir;
    logic       ir_valid;
    logic       ir_ready;

    modport master (
        input  pcoe, pcin, halt, mem_ack, mem_data, ir_ready,
        output pcout, mem_req, mem_addr, ir, ir_valid
    );

    modport slave (
        output pcoe, pcin, halt, mem_ack, mem_data, ir_ready,
        input  pcout, mem_req, mem_addr, ir, ir_valid
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch unit.
// Issues one byte fetch at a time, holds the result in ir until the decoder
// takes it, and redirects on jumps. A jump that lands while a fetch is in
// flight marks that fetch for discard when its ack finally arrives.
module pc_fetch #(
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_if.master    bus
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_pcout;
    logic [7:0] r_ir;
    logic       r_ir_valid;
    logic       r_flush;

    logic       w_jump;
    logic       w_ack;
    logic       w_accept;
    logic       w_discard;
    logic       w_xfer;
    logic       w_mem_req;

    // Event decode shared by the FSM and the datapath registers.
    always_comb begin
        w_jump    = bus.pcoe;
        w_ack     = (r_state == ST_WAIT) && bus.mem_ack;
        // A pending flush or a same-cycle jump turns the ack into a discard.
        w_accept  = w_ack && !r_flush && !w_jump;
        w_discard = w_ack && (r_flush || w_jump);
        // A jump in DELIVER overrides a simultaneous ready handshake.
        w_xfer    = (r_state == ST_DELIVER) && r_ir_valid && bus.ir_ready && !w_jump;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FETCH: begin
                if (!w_jump && !bus.halt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_accept) begin
                    w_state_nxt = ST_DELIVER;
                end else if (w_discard) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DELIVER: begin
                if (w_jump || w_xfer) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Outputs decoded from state: the request is live for the whole WAIT state.
    always_comb begin
        w_mem_req = (r_state == ST_WAIT);
    end

    // Program counter: a jump wins over the post-fetch increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcout <= RESET_VECTOR;
        end else if (w_jump) begin
            r_pcout <= bus.pcin;
        end else if (w_accept) begin
            r_pcout <= r_pcout + 8'd1;
        end
    end

    // Instruction register: captures only accepted fetch data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= '0;
        end else if (w_accept) begin
            r_ir <= bus.mem_data;
        end
    end

    // ir_valid: set on accepted data, cleared by transfer or a jump in DELIVER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir_valid <= 1'b0;
        end else if (w_accept) begin
            r_ir_valid <= 1'b1;
        end else if ((r_state == ST_DELIVER) && (w_jump || w_xfer)) begin
            r_ir_valid <= 1'b0;
        end
    end

    // Flush flag: armed by a jump during an outstanding fetch, cleared by its ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush <= 1'b0;
        end else if (w_ack) begin
            r_flush <= 1'b0;
        end else if ((r_state == ST_WAIT) && w_jump) begin
            r_flush <= 1'b1;
        end
    end

    assign bus.pcout    = r_pcout;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = r_pcout;
    assign bus.ir       = r_ir;
    assign bus.ir_valid = r_ir_valid;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: table-driven fetch vectors plus
// hand-written sequences for jumps, flushes, stalls and reset.
module tb_pc_fetch;

    logic clk;
    logic reset;

    int unsigned n_total;
    int unsigned n_bad;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  pcin;
        logic [7:0]  data;
        int unsigned ack_dly;
        int unsigned rdy_dly;
        logic [7:0]  exp_ir;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs[5];

    pc_fetch_if u_if ();

    pc_fetch #(.RESET_VECTOR(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Wait (bounded) for a request at exp_addr, idle dly cycles, then ack with data.
    task automatic do_fetch(input logic [7:0] exp_addr, input logic [7:0] data, input int unsigned dly);
        for (int t = 0; t < 8 && u_if.mem_req !== 1'b1; t++) tick();
        if (u_if.mem_req !== 1'b1) begin
            fail_now("req_timeout");
            return;
        end
        chk("req_addr", u_if.mem_addr, exp_addr);
        for (int unsigned i = 0; i < dly; i++) begin
            tick();
            chk("wait_req", {7'd0, u_if.mem_req}, 8'd1);
            chk("wait_addr", u_if.mem_addr, exp_addr);
        end
        u_if.mem_ack  = 1'b1;
        u_if.mem_data = data;
        tick();
        u_if.mem_ack  = 1'b0;
        u_if.mem_data = 8'h00;
    endtask

    // Decoder takes ir; compared against the scoreboard head.
    task automatic take(input logic hold);
        logic [7:0] e;
        chk("take_valid", {7'd0, u_if.ir_valid}, 8'd1);
        if (exp_q.size() == 0) begin
            fail_now("sb_empty");
        end else begin
            e = exp_q.pop_front();
            chk("sb_ir", u_if.ir, e);
        end
        u_if.ir_ready = 1'b1;
        u_if.halt     = hold;
        tick();
        u_if.ir_ready = 1'b0;
        chk("take_clr", {7'd0, u_if.ir_valid}, 8'd0);
        chk("take_noreq", {7'd0, u_if.mem_req}, 8'd0);
    endtask

    initial begin
        logic [7:0] seq_ir[3];
        logic [7:0] seq_pc[3];
        n_total = 0;
        n_bad   = 0;

        vecs[0] = '{pcin: 8'h20, data: 8'h3C, ack_dly: 0, rdy_dly: 0, exp_ir: 8'h3C, exp_pc: 8'h21};
        vecs[1] = '{pcin: 8'hFF, data: 8'h5A, ack_dly: 1, rdy_dly: 2, exp_ir: 8'h5A, exp_pc: 8'h00};
        vecs[2] = '{pcin: 8'h7F, data: 8'hC3, ack_dly: 3, rdy_dly: 1, exp_ir: 8'hC3, exp_pc: 8'h80};
        vecs[3] = '{pcin: 8'h00, data: 8'h00, ack_dly: 2, rdy_dly: 0, exp_ir: 8'h00, exp_pc: 8'h01};
        vecs[4] = '{pcin: 8'hFE, data: 8'h81, ack_dly: 0, rdy_dly: 3, exp_ir: 8'h81, exp_pc: 8'hFF};
        seq_ir[0] = 8'hA5; seq_ir[1] = 8'hA4; seq_ir[2] = 8'hA7;
        seq_pc[0] = 8'h01; seq_pc[1] = 8'h02; seq_pc[2] = 8'h03;

        u_if.pcoe = 1'b0; u_if.pcin = 8'h00; u_if.halt = 1'b0;
        u_if.mem_ack = 1'b0; u_if.mem_data = 8'h00; u_if.ir_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pcout", u_if.pcout, 8'h00);
        chk("rst_ir", u_if.ir, 8'h00);
        chk("rst_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("rst_req", {7'd0, u_if.mem_req}, 8'd0);
        tick();
        reset = 1'b1;
        #1 chk("rel_req", {7'd0, u_if.mem_req}, 8'd0);

        // Back-to-back stream, ack one cycle after request, data = addr ^ A5
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(seq_ir[k]);
            do_fetch(seq_pc[k] - 8'd1, (seq_pc[k] - 8'd1) ^ 8'hA5, 1);
            chk("seq_valid", {7'd0, u_if.ir_valid}, 8'd1);
            chk("seq_ir", u_if.ir, seq_ir[k]);
            chk("seq_pc", u_if.pcout, seq_pc[k]);
            take((k == 2) ? 1'b1 : 1'b0);
        end

        // Halt in FETCH
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("halt_req", {7'd0, u_if.mem_req}, 8'd0);
            chk("halt_pc", u_if.pcout, 8'h03);
        end

        // Table: jump in FETCH, fetch, stall decoder, deliver
        for (int v = 0; v < 5; v++) begin
            u_if.pcoe = 1'b1;
            u_if.pcin = vecs[v].pcin;
            tick();
            u_if.pcoe = 1'b0;
            chk("tv_jump_pc", u_if.pcout, vecs[v].pcin);
            chk("tv_jump_noreq", {7'd0, u_if.mem_req}, 8'd0);
            u_if.halt = 1'b0;
            exp_q.push_back(vecs[v].exp_ir);
            do_fetch(vecs[v].pcin, vecs[v].data, vecs[v].ack_dly);
            chk("tv_valid", {7'd0, u_if.ir_valid}, 8'd1);
            chk("tv_ir", u_if.ir, vecs[v].exp_ir);
            chk("tv_pc", u_if.pcout, vecs[v].exp_pc);
            chk("tv_noreq", {7'd0, u_if.mem_req}, 8'd0);
            for (int unsigned r = 0; r < vecs[v].rdy_dly; r++) begin
                tick();
                chk("tv_hold_ir", u_if.ir, vecs[v].exp_ir);
            end
            take(1'b1);
        end

        // Wrap at FF and 5-cycle decoder stall, then request one cycle after transfer
        u_if.halt = 1'b0;
        exp_q.push_back(8'h5A);
        do_fetch(8'hFF, 8'h5A, 0);
        chk("wrap_ir", u_if.ir, 8'h5A);
        chk("wrap_pc", u_if.pcout, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_ir", u_if.ir, 8'h5A);
            chk("stall_valid", {7'd0, u_if.ir_valid}, 8'd1);
            chk("stall_req", {7'd0, u_if.mem_req}, 8'd0);
        end
        take(1'b0);
        tick();
        chk("post_xfer_req", {7'd0, u_if.mem_req}, 8'd1);
        chk("post_xfer_addr", u_if.mem_addr, 8'h00);

        // Jump in WAIT, ack 3 cycles later is discarded
        u_if.pcoe = 1'b1;
        u_if.pcin = 8'h40;
        tick();
        u_if.pcoe = 1'b0;
        chk("flush_addr", u_if.mem_addr, 8'h40);
        chk("flush_req", {7'd0, u_if.mem_req}, 8'd1);
        tick();
        tick();
        u_if.mem_ack = 1'b1; u_if.mem_data = 8'h99;
        tick();
        u_if.mem_ack = 1'b0;
        chk("flush_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("flush_ir", u_if.ir, 8'h5A);
        chk("flush_noreq", {7'd0, u_if.mem_req}, 8'd0);
        chk("flush_pc", u_if.pcout, 8'h40);
        tick();
        chk("refetch_req", {7'd0, u_if.mem_req}, 8'd1);
        chk("refetch_addr", u_if.mem_addr, 8'h40);

        // Jump together with ack
        u_if.pcoe = 1'b1; u_if.pcin = 8'h10;
        u_if.mem_ack = 1'b1; u_if.mem_data = 8'h77;
        tick();
        u_if.pcoe = 1'b0; u_if.mem_ack = 1'b0;
        chk("jack_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("jack_ir", u_if.ir, 8'h5A);
        chk("jack_noreq", {7'd0, u_if.mem_req}, 8'd0);
        chk("jack_pc", u_if.pcout, 8'h10);
        do_fetch(8'h10, 8'hB5, 1);
        chk("jack_fetch_ir", u_if.ir, 8'hB5);
        chk("jack_fetch_pc", u_if.pcout, 8'h11);
        chk("jack_fetch_valid", {7'd0, u_if.ir_valid}, 8'd1);

        // Jump in DELIVER with simultaneous ready: no transfer
        u_if.pcoe = 1'b1; u_if.pcin = 8'h80; u_if.ir_ready = 1'b1;
        tick();
        u_if.pcoe = 1'b0; u_if.ir_ready = 1'b0;
        chk("djmp_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("djmp_pc", u_if.pcout, 8'h80);
        chk("djmp_noreq", {7'd0, u_if.mem_req}, 8'd0);
        tick();
        chk("djmp_req", {7'd0, u_if.mem_req}, 8'd1);
        chk("djmp_addr", u_if.mem_addr, 8'h80);

        // Two jumps while flushing: one discard, last target wins
        u_if.pcoe = 1'b1; u_if.pcin = 8'h30;
        tick();
        u_if.pcin = 8'h50;
        tick();
        u_if.pcoe = 1'b0;
        chk("dj_addr", u_if.mem_addr, 8'h50);
        chk("dj_req", {7'd0, u_if.mem_req}, 8'd1);
        u_if.mem_ack = 1'b1; u_if.mem_data = 8'hEE;
        tick();
        u_if.mem_ack = 1'b0;
        chk("dj_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("dj_ir", u_if.ir, 8'hB5);
        chk("dj_pc", u_if.pcout, 8'h50);
        exp_q.push_back(8'hF5);
        do_fetch(8'h50, 8'hF5, 0);
        chk("dj_fetch_ir", u_if.ir, 8'hF5);
        chk("dj_fetch_pc", u_if.pcout, 8'h51);
        // Stray ack in DELIVER is ignored
        u_if.mem_ack = 1'b1; u_if.mem_data = 8'h11;
        tick();
        u_if.mem_ack = 1'b0;
        chk("stray_ir", u_if.ir, 8'hF5);
        chk("stray_pc", u_if.pcout, 8'h51);
        chk("stray_valid", {7'd0, u_if.ir_valid}, 8'd1);
        take(1'b1);

        // Asynchronous reset mid-WAIT, stale ack after release ignored
        u_if.halt = 1'b0;
        tick();
        chk("pre_rst_req", {7'd0, u_if.mem_req}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_pc", u_if.pcout, 8'h00);
        chk("arst_ir", u_if.ir, 8'h00);
        chk("arst_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("arst_req", {7'd0, u_if.mem_req}, 8'd0);
        chk("arst_addr", u_if.mem_addr, 8'h00);
        @(negedge clk);
        u_if.mem_ack = 1'b1; u_if.mem_data = 8'h55;
        reset = 1'b1;
        #1 chk("rel2_req", {7'd0, u_if.mem_req}, 8'd0);
        tick();
        u_if.mem_ack = 1'b0;
        chk("stale_ir", u_if.ir, 8'h00);
        chk("stale_valid", {7'd0, u_if.ir_valid}, 8'd0);
        chk("stale_pc", u_if.pcout, 8'h00);
        chk("rel2_req_on", {7'd0, u_if.mem_req}, 8'd1);
        exp_q.push_back(8'hA5);
        do_fetch(8'h00, 8'hA5, 0);
        chk("post_rst_ir", u_if.ir, 8'hA5);
        chk("post_rst_pc", u_if.pcout, 8'h01);
        take(1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
